// File: rtl/cpu_stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_stack_pkg
//  Description : Shared widths, default depth and entry tag encodings for
//                the decode-stage operand stack and its writeback producer.
//  Revision    : 1.0 - initial parametrised operand stack support
// ============================================================================
package cpu_stack_pkg;

  // Entry layout: {tag[2:0], value[31:0]}
  localparam int STACK_TAG_W   = 3;
  localparam int STACK_VALUE_W = 32;
  localparam int STACK_WIDTH   = STACK_TAG_W + STACK_VALUE_W;  // 35
  localparam int STACK_POP_W   = 11;
  localparam int STACK_DEPTH   = 64;

  // Tag field encodings held in the top 3 bits of every entry
  typedef enum logic [STACK_TAG_W-1:0] {
    TAG_NONE  = 3'd0,
    TAG_INT   = 3'd1,
    TAG_ADDR  = 3'd2,
    TAG_RET   = 3'd3,
    TAG_FRAME = 3'd4,
    TAG_CONST = 3'd5
  } stack_tag_e;

  // Assemble an entry from its tag and 32-bit payload
  function automatic logic [STACK_WIDTH-1:0] stack_entry(
    input stack_tag_e                 tag,
    input logic [STACK_VALUE_W-1:0]   value
  );
    return {tag, value};
  endfunction

  // Extract the tag field from an entry
  function automatic stack_tag_e stack_tag(input logic [STACK_WIDTH-1:0] entry);
    return stack_tag_e'(entry[STACK_WIDTH-1 -: STACK_TAG_W]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_operand_stack.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_operand_stack
//  Description : DEPTH x WIDTH operand stack. Exposes the top TOPS entries
//                combinationally; applies one writeback update per cycle
//                (flush, else multi-entry pop then optional push) and keeps
//                occupancy plus sticky overflow/underflow flags.
//  Revision    : 1.0 - initial parametrised operand stack
// ============================================================================
module cpu_operand_stack
  import cpu_stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  parameter int TOPS  = 2,
  parameter int POP_W = STACK_POP_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st__pop,
  input  logic [POP_W-1:0]           st__to_pop,
  input  logic                       st__push,
  input  logic [WIDTH-1:0]           st__to_push,
  input  logic                       st__flush,
  input  logic                       st__err_clr,
  output logic [TOPS*WIDTH-1:0]      st__top,
  output logic [$clog2(DEPTH+1)-1:0] st__count,
  output logic                       st__empty,
  output logic                       st__full,
  output logic                       st__err_overflow,
  output logic                       st__err_underflow
);

  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Pop count and occupancy are compared at the wider of the two widths so a
  // large pop request never wraps into a small legal one.
  localparam int CMP_W  = (POP_W > CNT_W) ? POP_W : CNT_W;

  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  // Storage is deliberately not reset; only entries below r_count are visible
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             r_err_overflow;
  logic             r_err_underflow;

  logic [CMP_W-1:0] w_pop_n;
  logic [CMP_W-1:0] w_count_ext;
  logic             w_underflow;
  logic [CNT_W-1:0] w_c1;
  logic             w_push_ok;
  logic             w_overflow;
  logic [CNT_W-1:0] w_next_count;

  // Pop stage then push stage of the single per-cycle update
  always_comb begin
    w_pop_n      = st__pop ? CMP_W'(st__to_pop) : '0;
    w_count_ext  = CMP_W'(r_count);
    w_underflow  = (w_pop_n > w_count_ext);
    // Truncation is safe here: only taken when w_pop_n <= r_count
    w_c1         = w_underflow ? '0 : (r_count - CNT_W'(w_pop_n));
    w_push_ok    = st__push && (w_c1 < C_DEPTH);
    w_overflow   = st__push && !w_push_ok;
    w_next_count = w_push_ok ? (w_c1 + CNT_W'(1)) : w_c1;
  end

  // Occupancy and sticky error flags; flush discards entries but not errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count         <= '0;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if (st__flush) begin
        r_count <= '0;
      end else begin
        r_count <= w_next_count;
      end
      // A fresh error in the clearing cycle takes priority over the clear
      r_err_overflow  <= (r_err_overflow  & ~st__err_clr) | (w_overflow  & ~st__flush);
      r_err_underflow <= (r_err_underflow & ~st__err_clr) | (w_underflow & ~st__flush);
    end
  end

  // Entry write for an accepted push, landing just above the post-pop top
  always_ff @(posedge clk) begin
    if (!st__flush && w_push_ok) begin
      r_mem[w_c1[ADDR_W-1:0]] <= st__to_push;
    end
  end

  // Slice k shows the entry k below the top, or zeros past the bottom
  for (genvar k = 0; k < TOPS; k++) begin : g_top
    logic             w_valid;
    logic [CNT_W-1:0] w_idx;

    assign w_valid = (r_count > CNT_W'(k));
    assign w_idx   = r_count - CNT_W'(k + 1);
    assign st__top[k*WIDTH +: WIDTH] = w_valid ? r_mem[w_idx[ADDR_W-1:0]] : '0;
  end

  assign st__count         = r_count;
  assign st__empty         = (r_count == '0);
  assign st__full          = (r_count == C_DEPTH);
  assign st__err_overflow  = r_err_overflow;
  assign st__err_underflow = r_err_underflow;

endmodule
`default_nettype wire

// File: tb/tb_cpu_operand_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_operand_stack
//  Description : Self-checking bench for cpu_operand_stack. A queue-based
//                reference stack predicts each cycle's outputs; predictions
//                are queued when stimulus is driven and compared after the
//                applying clock edge.
//  Revision    : 1.0 - initial bench
// ============================================================================
module tb_cpu_operand_stack;
  import cpu_stack_pkg::*;

  localparam int WIDTH = STACK_WIDTH;
  localparam int DEPTH = 8;
  localparam int TOPS  = 3;
  localparam int POP_W = STACK_POP_W;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  st__pop;
  logic [POP_W-1:0]      st__to_pop;
  logic                  st__push;
  logic [WIDTH-1:0]      st__to_push;
  logic                  st__flush;
  logic                  st__err_clr;
  logic [TOPS*WIDTH-1:0] st__top;
  logic [CNT_W-1:0]      st__count;
  logic                  st__empty;
  logic                  st__full;
  logic                  st__err_overflow;
  logic                  st__err_underflow;

  always #5 clk = ~clk;

  cpu_operand_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .TOPS  (TOPS),
    .POP_W (POP_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .st__pop           (st__pop),
    .st__to_pop        (st__to_pop),
    .st__push          (st__push),
    .st__to_push       (st__to_push),
    .st__flush         (st__flush),
    .st__err_clr       (st__err_clr),
    .st__top           (st__top),
    .st__count         (st__count),
    .st__empty         (st__empty),
    .st__full          (st__full),
    .st__err_overflow  (st__err_overflow),
    .st__err_underflow (st__err_underflow)
  );

  typedef struct packed {
    logic [CNT_W-1:0]            cnt;
    logic                        empty;
    logic                        full;
    logic                        ovf;
    logic                        unf;
    logic [TOPS-1:0][WIDTH-1:0]  top;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] m_q[$];
  logic             m_ovf;
  logic             m_unf;
  int               total = 0;
  int               bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.cnt   = CNT_W'(m_q.size());
    e.empty = (m_q.size() == 0);
    e.full  = (m_q.size() == DEPTH);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    for (int k = 0; k < TOPS; k++)
      e.top[k] = (k < m_q.size()) ? m_q[m_q.size()-1-k] : '0;
    return e;
  endfunction

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_underrun"}, 64'(1), 64'(0));
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_count"}, 64'(st__count), 64'(e.cnt));
      chk({tag, "_empty"}, 64'(st__empty), 64'(e.empty));
      chk({tag, "_full"},  64'(st__full),  64'(e.full));
      chk({tag, "_ovf"},   64'(st__err_overflow),  64'(e.ovf));
      chk({tag, "_unf"},   64'(st__err_underflow), 64'(e.unf));
      for (int k = 0; k < TOPS; k++)
        chk($sformatf("%s_top%0d", tag, k), 64'(st__top[k*WIDTH +: WIDTH]), 64'(e.top[k]));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, 64'(st__count), 64'(0));
    chk({tag, "_empty"}, 64'(st__empty), 64'(1));
    chk({tag, "_full"},  64'(st__full),  64'(0));
    chk({tag, "_ovf"},   64'(st__err_overflow),  64'(0));
    chk({tag, "_unf"},   64'(st__err_underflow), 64'(0));
    chk({tag, "_top"},   64'(st__top != '0), 64'(0));
  endtask

  // Drive one update, predict its result, then compare after the edge
  task automatic step(input string tag, input logic pop, input logic [POP_W-1:0] n,
                      input logic push, input logic [WIDTH-1:0] val,
                      input logic flush, input logic clr);
    logic new_ovf, new_unf;
    st__pop     = pop;
    st__to_pop  = n;
    st__push    = push;
    st__to_push = val;
    st__flush   = flush;
    st__err_clr = clr;
    new_ovf = 1'b0;
    new_unf = 1'b0;
    if (flush) begin
      m_q.delete();
    end else begin
      if (pop) begin
        if (int'(n) > m_q.size()) begin
          m_q.delete();
          new_unf = 1'b1;
        end else begin
          repeat (int'(n)) void'(m_q.pop_back());
        end
      end
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(val);
        else new_ovf = 1'b1;
      end
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    m_ovf = m_ovf | new_ovf;
    m_unf = m_unf | new_unf;
    sb_q.push_back(model_snapshot());
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    st__pop = 1'b0; st__to_pop = '0; st__push = 1'b0; st__to_push = '0;
    st__flush = 1'b0; st__err_clr = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk); #1;
    chk_reset("reset");
    rst = 1'b0;

    // Basic pushes and the combined pop+push
    step("push1", 0, 0, 1, 35'h1, 0, 0);
    step("push2", 0, 0, 1, 35'h2, 0, 0);
    step("push3", 0, 0, 1, 35'h3, 0, 0);
    step("pop2_push7", 1, 2, 1, 35'h7, 0, 0);
    step("pop_n0", 1, 0, 0, '0, 0, 0);
    step("n_no_qual", 0, 3, 0, '0, 0, 0);

    // Fill to full, overflow, then replace-top while full
    for (int i = 0; i < DEPTH - 2; i++)
      step($sformatf("fill%0d", i), 0, 0, 1, stack_entry(TAG_INT, 32'(32'h10 + i)), 0, 0);
    step("ovf_push9", 0, 0, 1, 35'h9, 0, 0);
    step("full_pop1_pushA", 1, 1, 1, 35'hA, 0, 0);

    // Underflow with a wide pop count and the clear/set priority
    step("clr_ovf", 0, 0, 0, '0, 0, 1);
    step("pop6", 1, 6, 0, '0, 0, 0);
    step("unf_1024", 1, 11'd1024, 0, '0, 0, 0);
    step("clr_unf", 0, 0, 0, '0, 0, 1);
    step("clr_vs_unf", 1, 5, 0, '0, 0, 1);

    // Flush overrides simultaneous pop and push
    for (int i = 0; i < 5; i++)
      step($sformatf("pre_flush%0d", i), 0, 0, 1, stack_entry(TAG_ADDR, 32'(32'h100 + i)), 0, 0);
    step("flush", 1, 1, 1, 35'h5, 1, 0);
    step("push6", 0, 0, 1, 35'h6, 0, 0);

    // Asynchronous reset between edges during a push burst
    step("burst1", 0, 0, 1, 35'h11, 0, 0);
    st__push = 1'b1; st__to_push = 35'h12;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    @(posedge clk); #1;
    chk_reset("rst_hold");
    rst = 1'b0;
    st__push = 1'b0;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    step("post_rst_push", 0, 0, 1, stack_entry(TAG_RET, 32'hCAFE), 0, 0);

    st__pop = 1'b0; st__push = 1'b0; st__flush = 1'b0; st__err_clr = 1'b0;
    if (sb_q.size() != 0) chk("sb_leftover", 64'(sb_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
